// File: rtl/save_ram_arbiter.sv
// rtl/save_ram_arbiter.sv - single-port save RAM arbiter for core, RTC loader and bridge
//
// Shares one single-port save RAM (17-bit word address, 16-bit data) between
// three requesters: 0 = GB core, 1 = RTC loader, 2 = APF bridge.
// Every granted access completes in its grant cycle. Reads return RAM_LAT
// cycles later on the shared rdata bus, qualified per requester by rvalid.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   req/we/lock [2:0]         per-requester request, write flag, slot lock (bit 0 unused)
//   addr0..2, wdata0..2       per-requester word address and write data
//   gnt [2:0]                 one-hot grant, same cycle as the accepted request
//   rvalid [2:0], rdata       read return, rdata is ram_q passed straight through
//   ram_addr/ram_wdata/ram_we RAM command, zero when idle
//   ram_q                     RAM read data
module save_ram_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int RAM_LAT    = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [2:0]  lock,
    input  logic [16:0] addr0,
    input  logic [16:0] addr1,
    input  logic [16:0] addr2,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic [15:0] wdata2,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [15:0] rdata,
    output logic [16:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_q
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_RTC  = 2'd1,
        OWN_BRG  = 2'd2
    } owner_t;

    // rr_ptr_q = 0: RTC loader has round-robin preference; 1: bridge has it.
    logic          rr_ptr_q,     rr_ptr_d;
    owner_t        lock_owner_q, lock_owner_d;
    logic [CW-1:0] starve1_q,    starve1_d;
    logic [CW-1:0] starve2_q,    starve2_d;
    logic [2:0]    tag_q [RAM_LAT];
    logic [2:0]    tag_d [RAM_LAT];

    logic [2:0]    gnt_raw;
    logic          urg1, urg2;
    logic          unused_lock0;

    assign unused_lock0 = lock[0];

    assign urg1 = req[1] && (starve1_q == STARVE_LIM);
    assign urg2 = req[2] && (starve2_q == STARVE_LIM);

    // Net priority: urgent requester, core, lock owner, round-robin.
    always_comb begin
        gnt_raw = 3'b000;
        if (urg1 && urg2) begin
            gnt_raw = rr_ptr_q ? 3'b100 : 3'b010;
        end else if (urg1) begin
            gnt_raw = 3'b010;
        end else if (urg2) begin
            gnt_raw = 3'b100;
        end else if (req[0]) begin
            gnt_raw = 3'b001;
        end else if (lock_owner_q == OWN_RTC && req[1]) begin
            gnt_raw = 3'b010;
        end else if (lock_owner_q == OWN_BRG && req[2]) begin
            gnt_raw = 3'b100;
        end else if (req[1] && (!rr_ptr_q || !req[2])) begin
            gnt_raw = 3'b010;
        end else if (req[2]) begin
            gnt_raw = 3'b100;
        end
    end

    // The grant is combinational from req, so it is gated by reset_n to make
    // the RAM command go quiet as soon as reset is asserted.
    assign gnt = reset_n ? gnt_raw : 3'b000;

    always_comb begin
        ram_addr  = 17'd0;
        ram_wdata = 16'd0;
        if (gnt[0]) begin
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (gnt[1]) begin
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end else if (gnt[2]) begin
            ram_addr  = addr2;
            ram_wdata = wdata2;
        end
    end

    assign ram_we = |(gnt & we);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt[1]) begin
            rr_ptr_d = 1'b1;
        end else if (gnt[2]) begin
            rr_ptr_d = 1'b0;
        end
    end

    // A new locked grant takes ownership; otherwise the owner keeps it until
    // its own req or lock drops, even if it was preempted this cycle.
    always_comb begin
        lock_owner_d = lock_owner_q;
        if (gnt[1] && lock[1]) begin
            lock_owner_d = OWN_RTC;
        end else if (gnt[2] && lock[2]) begin
            lock_owner_d = OWN_BRG;
        end else if (lock_owner_q == OWN_RTC && (!req[1] || !lock[1])) begin
            lock_owner_d = OWN_NONE;
        end else if (lock_owner_q == OWN_BRG && (!req[2] || !lock[2])) begin
            lock_owner_d = OWN_NONE;
        end
    end

    always_comb begin
        starve1_d = starve1_q;
        if (gnt[1] || !req[1]) begin
            starve1_d = '0;
        end else if (starve1_q != STARVE_LIM) begin
            starve1_d = starve1_q + 1'b1;
        end
        starve2_d = starve2_q;
        if (gnt[2] || !req[2]) begin
            starve2_d = '0;
        end else if (starve2_q != STARVE_LIM) begin
            starve2_d = starve2_q + 1'b1;
        end
    end

    // Read-return tags ride alongside the RAM's own read latency.
    always_comb begin
        tag_d[0] = gnt & ~we;
        for (int k = 1; k < RAM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q     <= 1'b0;
            lock_owner_q <= OWN_NONE;
            starve1_q    <= '0;
            starve2_q    <= '0;
            for (int k = 0; k < RAM_LAT; k++) begin
                tag_q[k] <= 3'b000;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            starve1_q    <= starve1_d;
            starve2_q    <= starve2_d;
            for (int k = 0; k < RAM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign rvalid = tag_q[RAM_LAT-1];
    assign rdata  = ram_q;

endmodule
